note_sequencer: RTL



---
 rtl/tone_pkg.sv | 34 +++
 rtl/note_fifo.sv | 74 +++++++
 rtl/note_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator and the note sequencer:
// note codes, sequencer state encoding and the note frequency table.
package tone_pkg;

  localparam logic [2:0] NOTE_A    = 3'd0;
  localparam logic [2:0] NOTE_B    = 3'd1;
  localparam logic [2:0] NOTE_C    = 3'd2;
  localparam logic [2:0] NOTE_D    = 3'd3;
  localparam logic [2:0] NOTE_E    = 3'd4;
  localparam logic [2:0] NOTE_F    = 3'd5;
  localparam logic [2:0] NOTE_G    = 3'd6;
  localparam logic [2:0] NOTE_REST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

  // Fourth-octave pitches in Hz; a rest has no frequency.
  function automatic int unsigned note_freq_hz(input logic [2:0] note);
    case (note)
      NOTE_A:  note_freq_hz = 440;
      NOTE_B:  note_freq_hz = 494;
      NOTE_C:  note_freq_hz = 262;
      NOTE_D:  note_freq_hz = 294;
      NOTE_E:  note_freq_hz = 330;
      NOTE_F:  note_freq_hz = 349;
      NOTE_G:  note_freq_hz = 392;
      default: note_freq_hz = 0;
    endcase
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO for queued note commands. A pop frees its slot in the
// same cycle, so push and pop together are both honoured even when full.
module note_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued {note, duration} commands: drives the tone generator's note
// select and gate, timing each note in beat ticks from an internal prescaler.
// Command handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on queue-full and stop.
module note_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BEAT_HZ    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DUR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_note,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             stop,
  output logic [2:0]       note_sel,
  output logic             note_on,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int TICK_DIV = CLK_HZ / BEAT_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int ENTRY_W  = 3 + DUR_W;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  seq_state_e        state_q, state_d;
  logic [2:0]        note_q, note_d;
  logic [DUR_W-1:0]  remaining_q, remaining_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        note_sel_q, note_sel_d;
  logic              note_on_q, note_on_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_count_nxt;
  logic               fifo_push;
  logic               fifo_pop;
  logic [2:0]         head_note;
  logic [DUR_W-1:0]   head_dur;

  assign cmd_ready = !fifo_full && !stop;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == ST_LOAD) && !stop && !fifo_empty;
  assign head_note = fifo_dout[ENTRY_W-1 -: 3];
  assign head_dur  = fifo_dout[DUR_W-1:0];

  note_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (stop),
    .push  (fifo_push),
    .din   ({cmd_note, cmd_dur}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Queue occupancy after this edge, so busy can be registered without lag.
  assign fifo_count_nxt = stop ? '0
                        : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    remaining_d = remaining_q;
    tick_d      = tick_q;
    note_sel_d  = note_sel_q;
    done_d      = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      tick_d      = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          if (!fifo_empty) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          note_d = head_note;
          tick_d = '0;
          if (head_dur == '0) begin
            // Zero-length entries are skipped without sounding.
            remaining_d = '0;
            if (fifo_count > CNT_W'(1)) begin
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            remaining_d = head_dur;
            state_d     = ST_PLAY;
            if (head_note != NOTE_REST) begin
              note_sel_d = head_note;
            end
          end
        end
        ST_PLAY: begin
          if (tick_q == TICK_W'(TICK_DIV - 1)) begin
            tick_d = '0;
            if (remaining_q == DUR_W'(1)) begin
              remaining_d = '0;
              if (!fifo_empty) begin
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              remaining_d = remaining_q - DUR_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    note_on_d = (state_d == ST_PLAY) && (note_d != NOTE_REST);
    busy_d    = (state_d != ST_IDLE) || (fifo_count_nxt != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      note_q      <= '0;
      remaining_q <= '0;
      tick_q      <= '0;
      note_sel_q  <= '0;
      note_on_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      note_sel_q  <= note_sel_d;
      note_on_q   <= note_on_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign note_sel  = note_sel_q;
  assign note_on   = note_on_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
